// File: rtl/jtag_pkg.sv
// Shared TAP definitions: 1149.1 state encoding, BYPASS opcode helper and the
// fixed Capture-IR pattern.
package jtag_pkg;

   localparam logic [3:0] ST_EX2_DR = 4'h0;
   localparam logic [3:0] ST_EX1_DR = 4'h1;
   localparam logic [3:0] ST_SHF_DR = 4'h2;
   localparam logic [3:0] ST_PAU_DR = 4'h3;
   localparam logic [3:0] ST_SEL_IR = 4'h4;
   localparam logic [3:0] ST_UPD_DR = 4'h5;
   localparam logic [3:0] ST_CAP_DR = 4'h6;
   localparam logic [3:0] ST_SEL_DR = 4'h7;
   localparam logic [3:0] ST_EX2_IR = 4'h8;
   localparam logic [3:0] ST_EX1_IR = 4'h9;
   localparam logic [3:0] ST_SHF_IR = 4'hA;
   localparam logic [3:0] ST_PAU_IR = 4'hB;
   localparam logic [3:0] ST_RTI    = 4'hC;
   localparam logic [3:0] ST_UPD_IR = 4'hD;
   localparam logic [3:0] ST_CAP_IR = 4'hE;
   localparam logic [3:0] ST_TLR    = 4'hF;

   typedef enum logic [3:0] {
      TS_EX2_DR = ST_EX2_DR,
      TS_EX1_DR = ST_EX1_DR,
      TS_SHF_DR = ST_SHF_DR,
      TS_PAU_DR = ST_PAU_DR,
      TS_SEL_IR = ST_SEL_IR,
      TS_UPD_DR = ST_UPD_DR,
      TS_CAP_DR = ST_CAP_DR,
      TS_SEL_DR = ST_SEL_DR,
      TS_EX2_IR = ST_EX2_IR,
      TS_EX1_IR = ST_EX1_IR,
      TS_SHF_IR = ST_SHF_IR,
      TS_PAU_IR = ST_PAU_IR,
      TS_RTI    = ST_RTI,
      TS_UPD_IR = ST_UPD_IR,
      TS_CAP_IR = ST_CAP_IR,
      TS_TLR    = ST_TLR
   } tap_state_t;

   localparam int unsigned IDCODE_WIDTH = 32;

   // Low two bits of the Capture-IR value; upper bits are zero-filled.
   localparam logic [1:0] IR_CAPTURE = 2'b01;

   function automatic logic [31:0] bypass_opcode(input int unsigned w);
      if (w >= 32)
         return '1;
      else
         return (32'h1 << w) - 32'h1;
   endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state 1149.1 TAP sequencer: registered state plus Moore decodes of the
// states the data/instruction paths act on.
module jtag_tap_fsm
   import jtag_pkg::*;
(
   input  logic       TCK,
   input  logic       TRST,
   input  logic       TMS,
   output tap_state_t state,
   output logic       tlr,
   output logic       cap_dr,
   output logic       shf_dr,
   output logic       upd_dr,
   output logic       cap_ir,
   output logic       shf_ir,
   output logic       upd_ir
);

   // state  | meaning
   // TLR    | test-logic-reset, all test logic idle
   // RTI    | run-test/idle
   // SEL_xR | choose DR or IR column
   // CAP_xR | parallel load of selected register
   // SHF_xR | serial shift TDI -> register -> TDO
   // EX1/2  | exit states around pause
   // PAU_xR | shift paused, registers hold
   // UPD_xR | commit shifted value

   tap_state_t state_nxt;

   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST)
         state <= TS_TLR;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      tlr       = 1'b0;
      cap_dr    = 1'b0;
      shf_dr    = 1'b0;
      upd_dr    = 1'b0;
      cap_ir    = 1'b0;
      shf_ir    = 1'b0;
      upd_ir    = 1'b0;
      case (state)
         TS_TLR: begin
            tlr       = 1'b1;
            state_nxt = TMS ? TS_TLR : TS_RTI;
         end
         TS_RTI:    state_nxt = TMS ? TS_SEL_DR : TS_RTI;
         TS_SEL_DR: state_nxt = TMS ? TS_SEL_IR : TS_CAP_DR;
         TS_CAP_DR: begin
            cap_dr    = 1'b1;
            state_nxt = TMS ? TS_EX1_DR : TS_SHF_DR;
         end
         TS_SHF_DR: begin
            shf_dr    = 1'b1;
            state_nxt = TMS ? TS_EX1_DR : TS_SHF_DR;
         end
         TS_EX1_DR: state_nxt = TMS ? TS_UPD_DR : TS_PAU_DR;
         TS_PAU_DR: state_nxt = TMS ? TS_EX2_DR : TS_PAU_DR;
         TS_EX2_DR: state_nxt = TMS ? TS_UPD_DR : TS_SHF_DR;
         TS_UPD_DR: begin
            upd_dr    = 1'b1;
            state_nxt = TMS ? TS_SEL_DR : TS_RTI;
         end
         TS_SEL_IR: state_nxt = TMS ? TS_TLR : TS_CAP_IR;
         TS_CAP_IR: begin
            cap_ir    = 1'b1;
            state_nxt = TMS ? TS_EX1_IR : TS_SHF_IR;
         end
         TS_SHF_IR: begin
            shf_ir    = 1'b1;
            state_nxt = TMS ? TS_EX1_IR : TS_SHF_IR;
         end
         TS_EX1_IR: state_nxt = TMS ? TS_UPD_IR : TS_PAU_IR;
         TS_PAU_IR: state_nxt = TMS ? TS_EX2_IR : TS_PAU_IR;
         TS_EX2_IR: state_nxt = TMS ? TS_UPD_IR : TS_SHF_IR;
         TS_UPD_IR: begin
            upd_ir    = 1'b1;
            state_nxt = TMS ? TS_SEL_DR : TS_RTI;
         end
         default:   state_nxt = TS_TLR;
      endcase
   end

endmodule

// File: rtl/jtag_tap_ir.sv
// JTAG TAP with instruction register, BYPASS/IDCODE data registers and
// decoded user DR channels sharing a negedge-registered TDO.
module jtag_tap_ir
   import jtag_pkg::*;
#(
   parameter int unsigned           IR_WIDTH      = 4,
   parameter logic [31:0]           IDCODE_VAL    = 32'h1000_0001,
   parameter logic [IR_WIDTH-1:0]   OPC_IDCODE    = 4'b0001,
   parameter int unsigned           NUM_USER      = 2,
   parameter logic [IR_WIDTH-1:0]   OPC_USER_BASE = 4'b1000
) (
   input  logic                  TCK,
   input  logic                  TRST,
   input  logic                  TMS,
   input  logic                  TDI,
   output logic                  TDO,
   output logic                  TDO_EN,
   input  logic [NUM_USER-1:0]   USER_TDO,
   output logic [NUM_USER-1:0]   USER_SEL,
   output logic                  CAPTURE_DR,
   output logic                  SHIFT_DR,
   output logic                  UPDATE_DR,
   output logic [IR_WIDTH-1:0]   IR,
   output logic                  TLR
);

   localparam logic [IR_WIDTH-1:0] OPC_BYPASS = IR_WIDTH'(bypass_opcode(IR_WIDTH));
   localparam logic [IR_WIDTH-1:0] IR_CAP     = IR_WIDTH'(IR_CAPTURE);

   tap_state_t                  state;
   logic                        tlr;
   logic                        cap_dr, shf_dr, upd_dr;
   logic                        cap_ir, shf_ir, upd_ir;
   logic [IR_WIDTH-1:0]         ir_sr;
   logic                        bypass_q;
   logic [IDCODE_WIDTH-1:0]     idcode_sr;
   logic [NUM_USER-1:0]         user_hit;
   logic                        sel_idcode;
   logic                        sel_user;
   logic                        dr_tdo;

   jtag_tap_fsm u_fsm (
      .TCK    (TCK),
      .TRST   (TRST),
      .TMS    (TMS),
      .state  (state),
      .tlr    (tlr),
      .cap_dr (cap_dr),
      .shf_dr (shf_dr),
      .upd_dr (upd_dr),
      .cap_ir (cap_ir),
      .shf_ir (shf_ir),
      .upd_ir (upd_ir)
   );

   // All-ones always means BYPASS, even if it falls inside the user range.
   for (genvar k = 0; k < NUM_USER; k++) begin : g_user
      assign user_hit[k] = !tlr
                           && (IR == OPC_USER_BASE + IR_WIDTH'(k))
                           && (IR != OPC_BYPASS)
                           && (IR != OPC_IDCODE);
   end

   assign sel_idcode = (IR == OPC_IDCODE);
   assign sel_user   = |user_hit;
   assign USER_SEL   = user_hit;
   assign TLR        = tlr;
   assign CAPTURE_DR = cap_dr && sel_user;
   assign SHIFT_DR   = shf_dr && sel_user;
   assign UPDATE_DR  = upd_dr && sel_user;

   always_comb begin
      dr_tdo = bypass_q;
      if (sel_user)
         dr_tdo = |(USER_TDO & user_hit);
      else if (sel_idcode)
         dr_tdo = idcode_sr[0];
   end

   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST)
         ir_sr <= '0;
      else if (tlr)
         ir_sr <= '0;
      else if (cap_ir)
         ir_sr <= IR_CAP;
      else if (shf_ir)
         ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]};
   end

   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST) begin
         bypass_q  <= 1'b0;
         idcode_sr <= IDCODE_VAL;
      end else if (tlr) begin
         bypass_q  <= 1'b0;
         idcode_sr <= IDCODE_VAL;
      end else begin
         if (!sel_user && !sel_idcode) begin
            if (cap_dr)
               bypass_q <= 1'b0;
            else if (shf_dr)
               bypass_q <= TDI;
         end
         if (sel_idcode) begin
            if (cap_dr)
               idcode_sr <= IDCODE_VAL;
            else if (shf_dr)
               idcode_sr <= {TDI, idcode_sr[IDCODE_WIDTH-1:1]};
         end
      end
   end

   // Instruction commits on the falling edge so the decode is stable for the
   // whole following cycle.
   always_ff @(negedge TCK or posedge TRST) begin
      if (TRST)
         IR <= OPC_IDCODE;
      else if (tlr)
         IR <= OPC_IDCODE;
      else if (upd_ir)
         IR <= ir_sr;
   end

   always_ff @(negedge TCK or posedge TRST) begin
      if (TRST) begin
         TDO    <= 1'b0;
         TDO_EN <= 1'b0;
      end else begin
         case (state)
            TS_SHF_IR: begin
               TDO    <= ir_sr[0];
               TDO_EN <= 1'b1;
            end
            TS_SHF_DR: begin
               TDO    <= dr_tdo;
               TDO_EN <= 1'b1;
            end
            default: begin
               TDO    <= 1'b0;
               TDO_EN <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jtag_tap_ir.sv
// Directed bench for jtag_tap_ir: reset, IDCODE readout, BYPASS, user channel,
// TMS reset path and asynchronous TRST during a shift.
module tb_jtag_tap_ir;

   logic       TCK = 1'b0;
   logic       TRST;
   logic       TMS;
   logic       TDI;
   logic       TDO;
   logic       TDO_EN;
   logic [1:0] USER_TDO;
   logic [1:0] USER_SEL;
   logic       CAPTURE_DR;
   logic       SHIFT_DR;
   logic       UPDATE_DR;
   logic [3:0] IR;
   logic       TLR;

   int n_chk  = 0;
   int n_fail = 0;

   jtag_tap_ir dut (
      .TCK        (TCK),
      .TRST       (TRST),
      .TMS        (TMS),
      .TDI        (TDI),
      .TDO        (TDO),
      .TDO_EN     (TDO_EN),
      .USER_TDO   (USER_TDO),
      .USER_SEL   (USER_SEL),
      .CAPTURE_DR (CAPTURE_DR),
      .SHIFT_DR   (SHIFT_DR),
      .UPDATE_DR  (UPDATE_DR),
      .IR         (IR),
      .TLR        (TLR)
   );

   always #10 TCK = ~TCK;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // One TCK period: returns TDO/TDO_EN as registered on the falling edge of
   // the current state, then applies TMS/TDI for the next rising edge.
   task automatic clk(input logic tms, input logic tdi, output logic tdo_s, output logic en_s);
      @(negedge TCK);
      #2;
      tdo_s = TDO;
      en_s  = TDO_EN;
      TMS   = tms;
      TDI   = tdi;
      @(posedge TCK);
      #2;
   endtask

   // RTI -> Shift-IR, shift 4 bits LSB first, stop in Update-IR.
   task automatic shift_ir(input logic [3:0] val, output logic [3:0] cap);
      logic b, e;
      clk(1'b1, 1'b0, b, e);
      clk(1'b1, 1'b0, b, e);
      clk(1'b0, 1'b0, b, e);
      clk(1'b0, 1'b0, b, e);
      for (int i = 0; i < 4; i++) begin
         clk(i == 3, val[i], b, e);
         cap[i] = b;
      end
      clk(1'b1, 1'b0, b, e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        b, e;
      logic [31:0] word;
      logic [3:0]  cap;
      logic [2:0]  bp;

      TRST     = 1'b1;
      TMS      = 1'b1;
      TDI      = 1'b0;
      USER_TDO = 2'b00;
      #15;
      check("rst_tlr",    32'(TLR), 32'h1);
      check("rst_ir",     32'(IR), 32'h1);
      check("rst_tdo_en", 32'(TDO_EN), 32'h0);
      check("rst_tdo",    32'(TDO), 32'h0);
      check("rst_user",   32'(USER_SEL), 32'h0);
      @(negedge TCK);
      #2;
      TRST = 1'b0;

      clk(1'b0, 1'b0, b, e);
      check("rti_tlr",  32'(TLR), 32'h0);
      check("rti_ir",   32'(IR), 32'h1);
      check("rti_user", 32'(USER_SEL), 32'h0);

      // IDCODE readout
      clk(1'b1, 1'b0, b, e);
      check("rti_tdo_en", 32'(e), 32'h0);
      clk(1'b0, 1'b0, b, e);
      clk(1'b0, 1'b0, b, e);
      word = '0;
      for (int i = 0; i < 32; i++) begin
         clk(i == 31, 1'b0, b, e);
         word[i] = b;
         if (i == 0) check("idc_en0", 32'(e), 32'h1);
         if (i == 31) check("idc_en31", 32'(e), 32'h1);
      end
      check("idcode", word, 32'h1000_0001);
      clk(1'b1, 1'b0, b, e);
      check("ex1_tdo_en", 32'(e), 32'h0);
      clk(1'b0, 1'b0, b, e);

      // BYPASS via all-ones
      shift_ir(4'b1111, cap);
      check("ir_cap_bits", 32'(cap), 32'h1);
      check("ir_hold_upd", 32'(IR), 32'h1);
      clk(1'b0, 1'b0, b, e);
      check("ir_bypass", 32'(IR), 32'hF);
      check("byp_user", 32'(USER_SEL), 32'h0);
      clk(1'b1, 1'b0, b, e);
      clk(1'b0, 1'b0, b, e);
      check("byp_cap_strobe", 32'(CAPTURE_DR), 32'h0);
      clk(1'b0, 1'b0, b, e);
      check("byp_shf_strobe", 32'(SHIFT_DR), 32'h0);
      clk(1'b0, 1'b1, b, e); bp[0] = b;
      clk(1'b0, 1'b0, b, e); bp[1] = b;
      clk(1'b1, 1'b1, b, e); bp[2] = b;
      check("bypass_stream", 32'(bp), 32'h2);
      clk(1'b1, 1'b0, b, e);
      clk(1'b0, 1'b0, b, e);

      // user channel 1
      USER_TDO = 2'b10;
      shift_ir(4'b1001, cap);
      check("ir_cap_bits2", 32'(cap), 32'h1);
      clk(1'b0, 1'b0, b, e);
      check("ir_user1", 32'(IR), 32'h9);
      check("user_sel", 32'(USER_SEL), 32'h2);
      clk(1'b1, 1'b0, b, e);
      check("seldr_cap", 32'(CAPTURE_DR), 32'h0);
      clk(1'b0, 1'b0, b, e);
      check("capdr_cap", 32'(CAPTURE_DR), 32'h1);
      check("capdr_shf", 32'(SHIFT_DR), 32'h0);
      clk(1'b0, 1'b0, b, e);
      check("shfdr_cap", 32'(CAPTURE_DR), 32'h0);
      check("shfdr_shf", 32'(SHIFT_DR), 32'h1);
      clk(1'b0, 1'b0, b, e);
      check("user_tdo1", 32'(b), 32'h1);
      check("user_en",   32'(e), 32'h1);
      USER_TDO = 2'b01;
      clk(1'b1, 1'b0, b, e);
      check("user_tdo0", 32'(b), 32'h0);
      check("ex1dr_shf", 32'(SHIFT_DR), 32'h0);
      check("ex1dr_upd", 32'(UPDATE_DR), 32'h0);
      clk(1'b1, 1'b0, b, e);
      check("upddr_upd", 32'(UPDATE_DR), 32'h1);
      clk(1'b0, 1'b0, b, e);
      check("rti_upd", 32'(UPDATE_DR), 32'h0);

      // partial IR shift then five TMS=1 edges
      clk(1'b1, 1'b0, b, e);
      clk(1'b1, 1'b0, b, e);
      clk(1'b0, 1'b0, b, e);
      clk(1'b0, 1'b0, b, e);
      clk(1'b0, 1'b1, b, e);
      for (int i = 0; i < 5; i++) clk(1'b1, 1'b0, b, e);
      check("tms5_tlr", 32'(TLR), 32'h1);
      clk(1'b1, 1'b0, b, e);
      check("tms5_ir",   32'(IR), 32'h1);
      check("tms5_user", 32'(USER_SEL), 32'h0);

      // asynchronous TRST in Shift-DR (IDCODE selected)
      clk(1'b0, 1'b0, b, e);
      clk(1'b1, 1'b0, b, e);
      clk(1'b0, 1'b0, b, e);
      clk(1'b0, 1'b0, b, e);
      @(negedge TCK);
      #2;
      check("pre_trst_tdo", 32'(TDO), 32'h1);
      check("pre_trst_en",  32'(TDO_EN), 32'h1);
      #3;
      TRST = 1'b1;
      #1;
      check("trst_tlr",  32'(TLR), 32'h1);
      check("trst_tdo",  32'(TDO), 32'h0);
      check("trst_en",   32'(TDO_EN), 32'h0);
      check("trst_ir",   32'(IR), 32'h1);
      check("trst_user", 32'(USER_SEL), 32'h0);
      check("trst_shf",  32'(SHIFT_DR), 32'h0);
      #10;
      TRST = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
